// File: rtl/cla_addsub_pipe.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready on both sides.
// Stage 1 registers the per-bit and per-group propagate/generate terms; stage 2 resolves the carries and registers the result.
module cla_addsub_pipe #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NG = WIDTH / GROUP;

  if (GROUP < 1 || GROUP > WIDTH || (WIDTH % GROUP) != 0) begin : g_bad_params
    $error("cla_addsub_pipe: WIDTH must be a positive multiple of GROUP");
  end

  // AND of v[lo..hi]; an empty span yields 1 so it acts as the identity in lookahead products
  function automatic logic and_span(input logic [WIDTH-1:0] v, input int lo, input int hi);
    logic r;
    r = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      if (i >= lo && i <= hi) begin
        r = r & v[i];
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // handshake / stage-advance
  logic s2_adv_s;
  logic s1_adv_s;
  logic accept_s;

  // stage 1 combinational
  logic [WIDTH-1:0] bx_s;
  logic             c0_s;
  logic [WIDTH-1:0] p_s;
  logic [WIDTH-1:0] g_s;
  logic [NG-1:0]    gp_s;
  logic [NG-1:0]    gg_s;

  // stage 1 registers
  logic             s1_valid_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] bx_r;
  logic             c0_r;
  logic             op_r;
  logic [WIDTH-1:0] p_r;
  logic [WIDTH-1:0] g_r;
  logic [NG-1:0]    gp_r;
  logic [NG-1:0]    gg_r;

  // stage 2 combinational
  logic [WIDTH-1:0] gp_w_s;
  logic [WIDTH-1:0] gg_w_s;
  logic [NG:0]      grp_c_s;
  logic [WIDTH:0]   bit_c_s;
  logic [WIDTH-1:0] sum_s;
  logic             cout_s;
  logic             ovf_s;
  logic             zero_s;

  // output registers
  logic             out_valid_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             ovf_r;
  logic             zero_r;

  // Operands and op are kept in stage 1 for visibility but the result is formed from p/g alone
  logic unused_s;
  assign unused_s = ^{a_r, bx_r, op_r, g_r};

  // Pipeline advance: a stage moves when its successor is empty or draining this cycle
  always_comb begin
    s2_adv_s = ~out_valid_r | out_ready;
    s1_adv_s = ~s1_valid_r | s2_adv_s;
    accept_s = in_valid & s1_adv_s;
  end

  assign in_ready = s1_adv_s;

  // Operand prep and per-bit / per-group propagate-generate
  always_comb begin
    bx_s = op ? ~b : b;
    c0_s = op ? 1'b1 : cin;
    p_s  = a ^ bx_s;
    g_s  = a & bx_s;
    gp_s = {NG{1'b0}};
    gg_s = {NG{1'b0}};
    for (int k = 0; k < NG; k++) begin
      gp_s[k] = and_span(p_s, k * GROUP, k * GROUP + GROUP - 1);
      for (int j = 0; j < GROUP; j++) begin
        gg_s[k] = gg_s[k] |
                  (g_s[k * GROUP + j] & and_span(p_s, k * GROUP + j + 1, k * GROUP + GROUP - 1));
      end
    end
  end

  // Stage 1 capture on accept; a bubble enters when the stage advances with no accept
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      a_r        <= {WIDTH{1'b0}};
      bx_r       <= {WIDTH{1'b0}};
      c0_r       <= 1'b0;
      op_r       <= 1'b0;
      p_r        <= {WIDTH{1'b0}};
      g_r        <= {WIDTH{1'b0}};
      gp_r       <= {NG{1'b0}};
      gg_r       <= {NG{1'b0}};
    end else if (accept_s) begin
      s1_valid_r <= 1'b1;
      a_r        <= a;
      bx_r       <= bx_s;
      c0_r       <= c0_s;
      op_r       <= op;
      p_r        <= p_s;
      g_r        <= g_s;
      gp_r       <= gp_s;
      gg_r       <= gg_s;
    end else if (s1_adv_s) begin
      s1_valid_r <= 1'b0;
    end
  end

  // Group carries as flat sum-of-products over GP/GG, then in-group carries from each C[k]
  always_comb begin
    gp_w_s             = {WIDTH{1'b0}};
    gg_w_s             = {WIDTH{1'b0}};
    gp_w_s[NG-1:0]     = gp_r;
    gg_w_s[NG-1:0]     = gg_r;
    grp_c_s            = {(NG + 1){1'b0}};
    bit_c_s            = {(WIDTH + 1){1'b0}};
    for (int k = 0; k <= NG; k++) begin
      grp_c_s[k] = c0_r & and_span(gp_w_s, 0, k - 1);
      for (int m = 0; m < k; m++) begin
        grp_c_s[k] = grp_c_s[k] | (gg_w_s[m] & and_span(gp_w_s, m + 1, k - 1));
      end
    end
    for (int k = 0; k < NG; k++) begin
      for (int j = 0; j < GROUP; j++) begin
        bit_c_s[k * GROUP + j] = grp_c_s[k] & and_span(p_r, k * GROUP, k * GROUP + j - 1);
        for (int l = 0; l < j; l++) begin
          bit_c_s[k * GROUP + j] = bit_c_s[k * GROUP + j] |
              (g_r[k * GROUP + l] & and_span(p_r, k * GROUP + l + 1, k * GROUP + j - 1));
        end
      end
    end
    bit_c_s[WIDTH] = grp_c_s[NG];
    sum_s  = p_r ^ bit_c_s[WIDTH-1:0];
    cout_s = grp_c_s[NG];
    ovf_s  = bit_c_s[WIDTH-1] ^ bit_c_s[WIDTH];
    zero_s = (sum_s == {WIDTH{1'b0}});
  end

  // Output registers: load only when stage 2 may advance, and hold the data across bubbles
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      sum_r       <= {WIDTH{1'b0}};
      cout_r      <= 1'b0;
      ovf_r       <= 1'b0;
      zero_r      <= 1'b0;
    end else if (s2_adv_s) begin
      out_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        sum_r  <= sum_s;
        cout_r <= cout_s;
        ovf_r  <= ovf_s;
        zero_r <= zero_s;
      end
    end
  end

  assign out_valid = out_valid_r;
  assign sum       = sum_r;
  assign cout      = cout_r;
  assign ovf       = ovf_r;
  assign zero      = zero_r;

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Scoreboard bench for cla_addsub_pipe: accepted operands push an arithmetic-model result, and a monitor pops and compares on each output transfer.
module tb_cla_addsub_pipe;
  localparam int W  = 16;
  localparam int G  = 4;
  localparam int RW = W + 3;

  logic         clk       = 1'b0;
  logic         rst       = 1'b1;
  logic         in_valid  = 1'b0;
  logic         in_ready;
  logic [W-1:0] a         = '0;
  logic [W-1:0] b         = '0;
  logic         cin       = 1'b0;
  logic         op        = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         zero;

  int checks   = 0;
  int failures = 0;
  int n_out    = 0;
  logic [RW-1:0] exp_q[$];

  cla_addsub_pipe #(.WIDTH(W), .GROUP(G)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .op(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic, unsigned for the carry, signed range test for overflow
  function automatic logic [RW-1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                          input logic mc, input logic mo);
    longint ua, ub, sa, sb, ur, sr;
    logic [W-1:0] s;
    logic c, o;
    ua = longint'(ma);
    ub = longint'(mb);
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    if (mo) begin
      ur = ua - ub;
      sr = sa - sb;
      c  = (ua >= ub);
    end else begin
      ur = ua + ub + longint'(mc);
      sr = sa + sb + longint'(mc);
      c  = (ur >= (longint'(1) << W));
    end
    s = W'(ur);
    o = (sr > ((longint'(1) << (W - 1)) - 1)) || (sr < -(longint'(1) << (W - 1)));
    return {s, c, o, (s == '0)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, want);
    end
  endtask

  task automatic rand_op();
    logic [W-1:0] corner [4];
    corner[0] = '0;
    corner[1] = '1;
    corner[2] = W'(1) << (W - 1);
    corner[3] = ~(W'(1) << (W - 1));
    a   = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
    b   = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
    cin = 1'($urandom);
    op  = 1'($urandom);
  endtask

  // Single op through an empty pipeline with out_ready=1: latency and spec values
  task automatic single(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                        input logic to, input logic [RW-1:0] want, input string nm);
    a = ta; b = tb_v; cin = tc; op = to; in_valid = 1'b1;
    @(negedge clk); chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk); chk({nm, "_lat1"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    @(negedge clk); chk({nm, "_lat2"}, 32'(out_valid), 32'd1);
    chk(nm, 32'({sum, cout, ovf, zero}), 32'(want));
    @(posedge clk); #1;
    @(negedge clk); chk({nm, "_drained"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
  endtask

  // Recorder: each accepted operand set queues its expected result; reset discards everything
  initial begin
    forever begin
      @(negedge clk);
      if (rst) exp_q.delete();
      else if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, op));
    end
  end

  // Monitor: compare on every transfer and check outputs stay frozen while stalled
  initial begin
    logic [RW-1:0] e;
    logic          hold_prev;
    logic [RW:0]   hold_snap;
    hold_prev = 1'b0;
    hold_snap = '0;
    forever begin
      @(negedge clk);
      if (hold_prev) chk("hold_stable", 32'({out_valid, sum, cout, ovf, zero}), 32'(hold_snap));
      if (rst) begin
        hold_prev = 1'b0;
      end else begin
        if (out_valid && out_ready) begin
          n_out++;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_result actual sum=0x%0h expected no result pending", sum);
          end else begin
            e = exp_q.pop_front();
            chk("result", 32'({sum, cout, ovf, zero}), 32'(e));
          end
        end
        hold_prev = out_valid && !out_ready;
        hold_snap = {out_valid, sum, cout, ovf, zero};
      end
    end
  end

  initial begin
    logic [RW-1:0] m0;
    logic [6:0]    vpat;
    int            nout0;
    int            waited;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_flags", 32'({cout, ovf, zero}), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    out_ready = 1'b1;
    single(16'hFFFF, 16'h0001, 1'b0, 1'b0, {16'h0000, 1'b1, 1'b0, 1'b1}, "add_wrap");
    single(16'h8000, 16'h0001, 1'b0, 1'b1, {16'h7FFF, 1'b1, 1'b1, 1'b0}, "sub_ovf");
    single(16'h0003, 16'h0005, 1'b0, 1'b1, {16'hFFFE, 1'b0, 1'b0, 1'b0}, "sub_borrow");
    single(16'h7FFF, 16'h0000, 1'b1, 1'b0, {16'h8000, 1'b0, 1'b1, 1'b0}, "add_cin_ovf");
    single(16'h1234, 16'h1234, 1'b1, 1'b1, {16'h0000, 1'b1, 1'b0, 1'b1}, "sub_eq_cin_ignored");

    // Back-to-back: four ops -> four results on consecutive cycles
    vpat  = '0;
    nout0 = n_out;
    for (int i = 0; i < 7; i++) begin
      if (i < 4) begin rand_op(); in_valid = 1'b1; end
      else in_valid = 1'b0;
      @(negedge clk);
      if (i < 4) chk("b2b_in_ready", 32'(in_ready), 32'd1);
      vpat[i] = out_valid;
      @(posedge clk); #1;
    end
    chk("b2b_valid_pattern", 32'(vpat), 32'(7'b0111100));
    chk("b2b_count", 32'(n_out - nout0), 32'd4);

    // Stall: out_ready low for 5 cycles while 3 ops are offered
    nout0     = n_out;
    out_ready = 1'b0;
    rand_op(); in_valid = 1'b1; m0 = model(a, b, cin, op);
    @(negedge clk); chk("stall_acc0", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rand_op();
    @(negedge clk); chk("stall_acc1", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rand_op();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_held", 32'({out_valid, sum, cout, ovf, zero}), 32'({1'b1, m0}));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk); chk("release_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1; in_valid = 1'b0;
    waited = 0;
    while (exp_q.size() != 0 && waited < 20) begin
      @(posedge clk); #1; waited++;
    end
    chk("stall_drain_done", 32'(exp_q.size()), 32'd0);
    chk("stall_count", 32'(n_out - nout0), 32'd3);

    // Reset with two ops in flight
    rand_op(); in_valid = 1'b1;
    @(posedge clk); #1;
    rand_op();
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_sum", 32'(sum), 32'd0);
    chk("rst_mid_flags", 32'({cout, ovf, zero}), 32'd0);
    nout0 = n_out;
    repeat (5) @(negedge clk);
    chk("rst_no_stale", 32'(n_out - nout0), 32'd0);
    @(posedge clk); #1;

    // Random traffic with random backpressure and occasional reset
    for (int i = 0; i < 4000; i++) begin
      rand_op();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 199) == 0);
      @(posedge clk); #1;
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    waited = 0;
    while (exp_q.size() != 0 && waited < 20) begin
      @(posedge clk); #1; waited++;
    end
    chk("random_drain_done", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    chk("final_idle", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
